// File: rtl/keypad_event_decoder.sv
// keypad_event_decoder: debounces the active-low keypad bitmap and queues
// per-key press/release events behind a valid/ready FIFO.
module keypad_event_decoder #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] keycode,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [3:0]  ev_key,
    output logic        ev_release,
    output logic [15:0] pressed,
    output logic        overflow,
    input  logic        clr_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] DB = 8'(DEBOUNCE_CYCLES);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    logic [15:0] s, smp, pending, diff, emit_mask;
    logic [7:0] cnt;
    logic upd, pop, push;
    logic [3:0] k;
    logic [4:0] mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count;

    // smp is the key-indexed, active-high view; k is the lowest pending key
    always_comb begin
        smp = '0;
        k = '0;
        for (int i = 0; i < 16; i++) smp[i] = ~keycode[15-i];
        for (int i = 15; i >= 0; i--) if (pending[i]) k = 4'(i);
    end

    assign upd = smp == s && cnt == DB - 8'd1;
    assign diff = upd ? pressed ^ s : '0;
    assign pop = ev_valid & ev_ready;
    assign push = |pending && (count < DEPTH || pop);
    assign emit_mask = push ? 16'(1) << k : '0;
    assign ev_valid = count != '0;
    assign {ev_release, ev_key} = ev_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s <= '0;
            cnt <= '0;
            pressed <= '0;
            pending <= '0;
            overflow <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            s <= smp;
            cnt <= smp != s ? '0 : cnt != DB ? cnt + 8'd1 : cnt;
            if (upd) pressed <= s;
            // an edge landing on a still-queued opposite edge cancels both
            pending <= (pending & ~emit_mask) ^ diff;
            overflow <= |(pending & ~emit_mask & diff) | (overflow & ~clr_overflow);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {~pressed[k], k};
    end
endmodule

// File: tb/tb_keypad_event_decoder.sv
// tb_keypad_event_decoder: directed checks of debounce, event ordering,
// FIFO backpressure, cancellation and reset behaviour.
module tb_keypad_event_decoder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ev_ready = 1'b0;
    logic clr_overflow = 1'b0;
    logic [15:0] keycode = 16'hFFFF;
    logic ev_valid, ev_release, overflow;
    logic [3:0] ev_key;
    logic [15:0] pressed;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    keypad_event_decoder dut (
        .clk(clk),
        .reset(reset),
        .keycode(keycode),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_key(ev_key),
        .ev_release(ev_release),
        .pressed(pressed),
        .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ev(input string tag, input logic v, input logic [3:0] key, input logic rel);
        chk({tag, ".valid"}, 16'(ev_valid), 16'(v));
        chk({tag, ".key"}, 16'(ev_key), 16'(key));
        chk({tag, ".rel"}, 16'(ev_release), 16'(rel));
    endtask

    initial begin
        step(3);
        chk_ev("rst", 0, 0, 0);
        chk("rst.pressed", pressed, 16'h0000);
        chk("rst.ovf", 16'(overflow), 16'h0);
        reset = 1'b1;
        step(2);

        // single key 5 press and release
        keycode = 16'hFBFF;
        step(20);
        chk("t1.pre", pressed, 16'h0000);
        step(1);
        chk("t1.pressed", pressed, 16'h0020);
        chk("t1.notyet", 16'(ev_valid), 16'h0);
        step(1);
        chk_ev("t1.press", 1, 5, 0);
        ev_ready = 1'b1;
        step(1);
        ev_ready = 1'b0;
        chk_ev("t1.empty", 0, 0, 0);
        step(15);
        chk("t1.single", 16'(ev_valid), 16'h0);
        keycode = 16'hFFFF;
        step(21);
        chk("t1.rpressed", pressed, 16'h0000);
        chk("t1.rnotyet", 16'(ev_valid), 16'h0);
        step(1);
        chk_ev("t1.release", 1, 5, 1);
        ev_ready = 1'b1;
        step(1);
        ev_ready = 1'b0;
        chk("t1.rempty", 16'(ev_valid), 16'h0);

        // bounce: toggling faster than the window never commits
        for (int i = 0; i < 10; i++) begin
            keycode = i[0] ? 16'hFBFF : 16'hFFFF;
            step(5);
        end
        chk("t2.bounce_p", pressed, 16'h0000);
        chk("t2.bounce_v", 16'(ev_valid), 16'h0);
        step(15);
        chk("t2.pre", pressed, 16'h0000);
        step(1);
        chk("t2.pressed", pressed, 16'h0020);
        step(1);
        chk_ev("t2.press", 1, 5, 0);
        ev_ready = 1'b1;
        step(1);
        ev_ready = 1'b0;
        step(10);
        chk("t2.single", 16'(ev_valid), 16'h0);
        keycode = 16'hFFFF;
        step(22);
        chk_ev("t2.release", 1, 5, 1);
        ev_ready = 1'b1;
        step(1);
        ev_ready = 1'b0;
        chk("t2.empty", 16'(ev_valid), 16'h0);

        // keys 0, 3, 15 together, streamed with ready high
        ev_ready = 1'b1;
        keycode = 16'h6FFE;
        step(21);
        chk("t3.pressed", pressed, 16'h8009);
        step(1);
        chk_ev("t3.k0", 1, 0, 0);
        step(1);
        chk_ev("t3.k3", 1, 3, 0);
        step(1);
        chk_ev("t3.k15", 1, 15, 0);
        step(1);
        chk("t3.empty", 16'(ev_valid), 16'h0);
        keycode = 16'hFFFF;
        step(25);
        chk("t3.drain", 16'(ev_valid), 16'h0);
        chk("t3.released", pressed, 16'h0000);
        ev_ready = 1'b0;

        // six keys with the consumer stalled: four queue, two wait
        keycode = ~16'h6AC0;
        step(21);
        chk("t4.pressed", pressed, 16'h0356);
        step(7);
        chk_ev("t4.head", 1, 1, 0);
        chk("t4.ovf", 16'(overflow), 16'h0);
        ev_ready = 1'b1;
        step(1);
        chk_ev("t4.k2", 1, 2, 0);
        step(1);
        chk_ev("t4.k4", 1, 4, 0);
        step(1);
        chk_ev("t4.k6", 1, 6, 0);
        step(1);
        chk_ev("t4.k8", 1, 8, 0);
        step(1);
        chk_ev("t4.k9", 1, 9, 0);
        step(1);
        chk("t4.empty", 16'(ev_valid), 16'h0);
        keycode = 16'hFFFF;
        step(30);
        chk("t4.drain", 16'(ev_valid), 16'h0);
        ev_ready = 1'b0;

        // key 7 pressed and released while the FIFO is full
        keycode = ~16'h6A00;
        step(25);
        chk_ev("t5.full", 1, 1, 0);
        keycode = ~16'h6B00;
        step(21);
        chk("t5.p7", pressed, 16'h00D6);
        chk("t5.ovf0", 16'(overflow), 16'h0);
        keycode = ~16'h6A00;
        step(21);
        chk("t5.r7", pressed, 16'h0056);
        chk("t5.ovf1", 16'(overflow), 16'h1);
        clr_overflow = 1'b1;
        step(1);
        clr_overflow = 1'b0;
        chk("t5.clr", 16'(overflow), 16'h0);
        chk_ev("t5.head", 1, 1, 0);
        ev_ready = 1'b1;
        step(1);
        chk_ev("t5.k2", 1, 2, 0);
        step(1);
        chk_ev("t5.k4", 1, 4, 0);
        step(1);
        chk_ev("t5.k6", 1, 6, 0);
        step(1);
        chk("t5.empty", 16'(ev_valid), 16'h0);
        step(3);
        chk("t5.no7", 16'(ev_valid), 16'h0);
        keycode = 16'hFFFF;
        step(28);
        chk("t5.drain", 16'(ev_valid), 16'h0);
        ev_ready = 1'b0;

        // reset with events queued and key 2 held
        keycode = 16'h1FFF;
        step(24);
        chk_ev("t6.queued", 1, 0, 0);
        reset = 1'b0;
        #2;
        chk_ev("t6.rst", 0, 0, 0);
        chk("t6.rst_p", pressed, 16'h0000);
        keycode = 16'hDFFF;
        step(3);
        reset = 1'b1;
        step(20);
        chk("t6.pre", pressed, 16'h0000);
        step(1);
        chk("t6.pressed", pressed, 16'h0004);
        chk("t6.notyet", 16'(ev_valid), 16'h0);
        step(1);
        chk_ev("t6.press", 1, 2, 0);
        step(3);
        chk_ev("t6.hold", 1, 2, 0);
        ev_ready = 1'b1;
        step(1);
        chk("t6.single", 16'(ev_valid), 16'h0);
        ev_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
